// File: rtl/command_interface_unit_if.sv
// Command byte bus between the host-side command source and the SCARA
// command decoder, plus the decoded motion command and acknowledge.
interface command_interface_unit_if;
   logic [7:0] cmd_data;
   logic       cmd_val;
   logic [2:0] motion_cmd;
   logic       cmd_ack;

   modport master (
      output cmd_data,
      output cmd_val,
      input  motion_cmd,
      input  cmd_ack
   );

   modport slave (
      input  cmd_data,
      input  cmd_val,
      output motion_cmd,
      output cmd_ack
   );
endinterface

// File: rtl/command_interface_unit.sv
// Front-end command decoder: edge-qualified opcode bytes become a registered
// 3-bit motion command with a one-cycle acknowledge per accepted command.
module command_interface_unit #(
   parameter logic [7:0] CMD_MOVE_X = 8'h04,
   parameter logic [7:0] CMD_MOVE_Y = 8'h14,
   parameter logic [7:0] CMD_HOME   = 8'h50,
   parameter logic [7:0] CMD_STOP   = 8'h54
) (
   input logic                      clock,
   input logic                      reset,
   command_interface_unit_if.slave  bus
);

   localparam logic [2:0] MC_IDLE   = 3'b000;
   localparam logic [2:0] MC_MOVE_X = 3'b001;
   localparam logic [2:0] MC_MOVE_Y = 3'b010;
   localparam logic [2:0] MC_HOME   = 3'b011;
   localparam logic [2:0] MC_STOP   = 3'b100;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_t;

   state_t     state_r;
   logic       cmd_val_prev_r;
   logic [2:0] motion_cmd_r;
   logic       cmd_ack_r;

   logic       accept_s;
   logic       decode_valid_s;
   logic [2:0] decode_code_s;

   // Exact 8-bit opcode match; returns {valid, motion code}.
   function automatic logic [3:0] decode_opcode(input logic [7:0] opcode);
      logic [3:0] result;
      result = {1'b0, MC_IDLE};
      if (opcode == CMD_MOVE_X) begin
         result = {1'b1, MC_MOVE_X};
      end else if (opcode == CMD_MOVE_Y) begin
         result = {1'b1, MC_MOVE_Y};
      end else if (opcode == CMD_HOME) begin
         result = {1'b1, MC_HOME};
      end else if (opcode == CMD_STOP) begin
         result = {1'b1, MC_STOP};
      end else begin
         result = {1'b0, MC_IDLE};
      end
      return result;
   endfunction

   // Rising-edge detect on the strobe and opcode decode.
   always_comb begin
      accept_s       = 1'b0;
      decode_valid_s = 1'b0;
      decode_code_s  = MC_IDLE;
      {decode_valid_s, decode_code_s} = decode_opcode(bus.cmd_data);
      if (bus.cmd_val && !cmd_val_prev_r) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Strobe history, acknowledge FSM and registered motion command.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= ST_IDLE;
         cmd_val_prev_r <= 1'b0;
         motion_cmd_r   <= MC_IDLE;
         cmd_ack_r      <= 1'b0;
      end else begin
         cmd_val_prev_r <= bus.cmd_val;
         case (state_r)
            ST_IDLE: begin
               if (accept_s && decode_valid_s) begin
                  motion_cmd_r <= decode_code_s;
                  cmd_ack_r    <= 1'b1;
                  state_r      <= ST_ACK;
               end else begin
                  cmd_ack_r    <= 1'b0;
                  state_r      <= ST_IDLE;
               end
            end
            // A fresh strobe edge cannot arrive here: the strobe was high last edge.
            ST_ACK: begin
               cmd_ack_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               cmd_ack_r <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.motion_cmd = motion_cmd_r;
   assign bus.cmd_ack    = cmd_ack_r;

endmodule

// File: tb/tb_command_interface_unit.sv
// Self-checking bench for command_interface_unit: directed scenarios followed
// by randomized strobes/bytes against a behavioural opcode-table model.
module tb_command_interface_unit;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   command_interface_unit_if cif ();

   command_interface_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (cif.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          code_of [byte unsigned];
   logic [2:0]  exp_m;
   logic        exp_a;
   logic        prev_val;

   task automatic check(input string tag, input logic [2:0] m_exp, input logic a_exp);
      checks = checks + 1;
      assert (cif.motion_cmd === m_exp) else begin
         failures = failures + 1;
         $error("FAIL %s motion_cmd got=%b expected=%b", tag, cif.motion_cmd, m_exp);
      end
      checks = checks + 1;
      assert (cif.cmd_ack === a_exp) else begin
         failures = failures + 1;
         $error("FAIL %s cmd_ack got=%b expected=%b", tag, cif.cmd_ack, a_exp);
      end
   endtask

   // Predict the outcome of the coming edge from current inputs, take it, compare.
   task automatic cycle(input string tag);
      if (!reset) begin
         exp_m    = 3'd0;
         exp_a    = 1'b0;
         prev_val = 1'b0;
      end else begin
         if (cif.cmd_val && !prev_val && code_of.exists(cif.cmd_data)) begin
            exp_m = 3'(code_of[cif.cmd_data]);
            exp_a = 1'b1;
         end else begin
            exp_a = 1'b0;
         end
         prev_val = cif.cmd_val;
      end
      @(posedge clock);
      #1;
      check(tag, exp_m, exp_a);
   endtask

   task automatic send(input logic [7:0] data, input string tag);
      cif.cmd_data = data;
      cif.cmd_val  = 1'b1;
      cycle(tag);
      cif.cmd_val  = 1'b0;
      cycle({tag, "_drop"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      byte unsigned opcodes [4];
      checks   = 0;
      failures = 0;
      code_of[8'h04] = 1;
      code_of[8'h14] = 2;
      code_of[8'h50] = 3;
      code_of[8'h54] = 4;
      opcodes = '{8'h04, 8'h14, 8'h50, 8'h54};
      exp_m    = 3'd0;
      exp_a    = 1'b0;
      prev_val = 1'b0;

      // Reset held low across edges, even with a valid strobe present.
      reset        = 1'b0;
      cif.cmd_data = 8'h04;
      cif.cmd_val  = 1'b1;
      #2;
      check("reset_async", 3'd0, 1'b0);
      cycle("reset_hold0");
      cycle("reset_hold1");
      cif.cmd_val = 1'b0;
      reset       = 1'b1;
      cycle("post_reset0");
      cycle("post_reset1");

      // Each opcode, repeated STOP, and invalid bytes.
      send(8'h04, "move_x");
      send(8'h14, "move_y");
      send(8'h50, "home");
      send(8'h54, "stop");
      send(8'h54, "stop_again");
      send(8'hFF, "invalid_ff");
      send(8'h00, "invalid_00");
      send(8'h05, "invalid_05");

      // Long hold: one acceptance only; data change mid-hold ignored.
      cif.cmd_data = 8'h04;
      cif.cmd_val  = 1'b1;
      cycle("hold0");
      cycle("hold1");
      cif.cmd_data = 8'h14;
      cycle("hold2");
      cycle("hold3");
      cif.cmd_val  = 1'b0;
      cycle("hold_end");

      // Reset asserted between edges while cmd_ack is high.
      send(8'h50, "pre_async");
      cif.cmd_data = 8'h14;
      cif.cmd_val  = 1'b1;
      cycle("ack_high");
      #2;
      reset = 1'b0;
      #1;
      check("async_mid_ack", 3'd0, 1'b0);
      cif.cmd_val = 1'b0;
      cycle("async_hold");
      reset = 1'b1;
      cycle("async_release");

      // Randomized strobes and bytes, biased toward known opcodes.
      for (int i = 0; i < 400; i++) begin
         cif.cmd_val = ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0;
         if ($urandom_range(0, 2) != 0) begin
            cif.cmd_data = opcodes[$urandom_range(0, 3)];
         end else begin
            cif.cmd_data = 8'($urandom);
         end
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0;
         end else begin
            reset = 1'b1;
         end
         cycle("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
